// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI-Lite command-to-bus master.
package axi_lite_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/AXI_LITE.sv
// AXI4-Lite signal bundle with master and slave views.
interface AXI_LITE;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or
// write and returns the response, aborting any handshake that stalls too long.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    AXI_LITE.master     axi
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_r;
    logic [15:0] wait_cnt_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic        cmd_ready_r;

    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic any_hs_s;
    logic wait_state_s;
    logic timeout_s;
    logic abort_s;
    logic accept_s;

    // Ready is forced low for as long as reset is held, not just after the edge.
    assign cmd_ready = cmd_ready_r & ~areset;

    // Handshake detection and timeout decision for the current cycle.
    always_comb begin
        aw_hs_s  = axi.awvalid & axi.awready;
        w_hs_s   = axi.wvalid  & axi.wready;
        b_hs_s   = axi.bvalid  & axi.bready;
        ar_hs_s  = axi.arvalid & axi.arready;
        r_hs_s   = axi.rvalid  & axi.rready;
        any_hs_s = aw_hs_s | w_hs_s | b_hs_s | ar_hs_s | r_hs_s;
        accept_s = cmd_valid & cmd_ready;
        case (state_r)
            ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP: wait_state_s = 1'b1;
            default:                                      wait_state_s = 1'b0;
        endcase
        timeout_s = (wait_cnt_r == TIMEOUT_LAST);
        abort_s   = wait_state_s & ~any_hs_s & timeout_s;
    end

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 16'd0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= 32'd0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= 32'd0;
            axi.wstrb   <= 4'd0;
            axi.wlast   <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= 32'd0;
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            // Counter only runs while stalled on the bus; any progress restarts it.
            if (!wait_state_s || any_hs_s || timeout_s) begin
                wait_cnt_r <= 16'd0;
            end else begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        if (cmd_write) begin
                            axi.awaddr  <= cmd_addr;
                            axi.wdata   <= cmd_wdata;
                            axi.wstrb   <= cmd_wstrb;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            axi.wlast   <= 1'b1;
                            state_r     <= ST_WR_REQ;
                        end else begin
                            axi.araddr  <= cmd_addr;
                            axi.arvalid <= 1'b1;
                            state_r     <= ST_RD_REQ;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs_s) begin
                        axi.awvalid <= 1'b0;
                        aw_done_r   <= 1'b1;
                    end
                    if (w_hs_s) begin
                        axi.wvalid <= 1'b0;
                        axi.wlast  <= 1'b0;
                        w_done_r   <= 1'b1;
                    end
                    if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                        axi.bready <= 1'b1;
                        state_r    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        axi.bready  <= 1'b0;
                        rsp_resp    <= axi.bresp;
                        rsp_rdata   <= 32'd0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_r     <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs_s) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state_r     <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs_s) begin
                        axi.rready  <= 1'b0;
                        rsp_rdata   <= axi.rdata;
                        rsp_resp    <= axi.rresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_r     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                end
            endcase

            // A stalled handshake overrides whatever the state would have done.
            if (abort_s) begin
                axi.awvalid <= 1'b0;
                axi.wvalid  <= 1'b0;
                axi.wlast   <= 1'b0;
                axi.bready  <= 1'b0;
                axi.arvalid <= 1'b0;
                axi.rready  <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_resp    <= RESP_SLVERR;
                rsp_rdata   <= 32'd0;
                rsp_timeout <= 1'b1;
                state_r     <= ST_RSP;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable AXI-Lite slave model.
module tb_axi_lite_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    AXI_LITE axi_bus ();

    axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi         (axi_bus)
    );

    always #5 aclk = ~aclk;

    // Slave configuration, written only by the stimulus process.
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          r_delay  = 0;
    logic        hang_wr  = 1'b0;
    logic        hold_b   = 1'b0;
    logic [1:0]  sl_bresp = 2'b00;
    logic [1:0]  sl_rresp = 2'b00;
    logic [31:0] sl_rdata = 32'd0;

    // Slave state and monitors, written only by the slave process.
    int          aw_cnt = 0, w_cnt = 0, r_cnt = 0;
    logic        s_aw_got = 1'b0, s_w_got = 1'b0, s_bvalid = 1'b0;
    logic        s_rvalid = 1'b0, r_pend = 1'b0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    int          awv_cycles = 0, wv_cycles = 0, wlast_bad = 0, stable_bad = 0;
    logic [31:0] aw_last = 32'd0, w_last = 32'd0, ar_last = 32'd0;
    logic [3:0]  strb_last = 4'd0;
    logic        aw_holding = 1'b0, w_holding = 1'b0;
    logic [31:0] aw_hold_addr = 32'd0, w_hold_data = 32'd0;
    logic [3:0]  w_hold_strb = 4'd0;

    logic aw_hs, w_hs, ar_hs, got_aw, got_w;

    assign axi_bus.awready = axi_bus.awvalid && !hang_wr && (aw_cnt >= aw_delay);
    assign axi_bus.wready  = axi_bus.wvalid  && !hang_wr && (w_cnt >= w_delay);
    assign axi_bus.arready = axi_bus.arvalid;
    assign axi_bus.bvalid  = s_bvalid;
    assign axi_bus.bresp   = sl_bresp;
    assign axi_bus.rvalid  = s_rvalid;
    assign axi_bus.rdata   = sl_rdata;
    assign axi_bus.rresp   = sl_rresp;

    assign aw_hs  = axi_bus.awvalid && axi_bus.awready;
    assign w_hs   = axi_bus.wvalid  && axi_bus.wready;
    assign ar_hs  = axi_bus.arvalid && axi_bus.arready;
    assign got_aw = s_aw_got || aw_hs;
    assign got_w  = s_w_got  || w_hs;

    // Slave model: delayed readies, B after both AW and W, R after r_delay cycles.
    always @(posedge aclk) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0;
            s_rvalid <= 1'b0; r_pend <= 1'b0;
            aw_holding <= 1'b0; w_holding <= 1'b0;
        end else begin
            if (axi_bus.awvalid) awv_cycles <= awv_cycles + 1;
            if (axi_bus.wvalid)  wv_cycles  <= wv_cycles + 1;
            if (aw_holding && axi_bus.awaddr != aw_hold_addr) stable_bad <= stable_bad + 1;
            if (w_holding && (axi_bus.wdata != w_hold_data || axi_bus.wstrb != w_hold_strb))
                stable_bad <= stable_bad + 1;
            aw_holding   <= axi_bus.awvalid && !aw_hs;
            aw_hold_addr <= axi_bus.awaddr;
            w_holding    <= axi_bus.wvalid && !w_hs;
            w_hold_data  <= axi_bus.wdata;
            w_hold_strb  <= axi_bus.wstrb;
            if (aw_hs) begin
                aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1; aw_last <= axi_bus.awaddr;
            end else if (axi_bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_cnt <= 0; w_hs_cnt <= w_hs_cnt + 1;
                w_last <= axi_bus.wdata; strb_last <= axi_bus.wstrb;
                if (!axi_bus.wlast) wlast_bad <= wlast_bad + 1;
            end else if (axi_bus.wvalid) w_cnt <= w_cnt + 1;
            if (got_aw && got_w && !hold_b && !s_bvalid) begin
                s_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end else begin
                s_aw_got <= got_aw; s_w_got <= got_w;
            end
            if (s_bvalid && axi_bus.bready) begin
                s_bvalid <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
            end
            if (ar_hs) begin
                ar_hs_cnt <= ar_hs_cnt + 1; ar_last <= axi_bus.araddr;
                if (r_delay == 0) s_rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= r_delay - 1; end
            end else if (r_pend) begin
                if (r_cnt == 0) begin s_rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt - 1;
            end
            if (s_rvalid && axi_bus.rready) begin
                s_rvalid <= 1'b0; r_hs_cnt <= r_hs_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Presents a command at a falling edge; returns at the falling edge one cycle after acceptance.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int n;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge aclk); n++; end
        check_eq("cmd_ready_wait", cmd_ready, 1);
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin @(negedge aclk); cyc++; end
        check_eq("rsp_seen", rsp_valid, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, aw0, w0, b0, ar0, awv0, wv0;
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
        check_eq("rst_valids", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
                                axi_bus.bready, axi_bus.rready, axi_bus.wlast}, 0);
        areset = 1'b0;
        #1;
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        @(negedge aclk);

        // Zero-wait write
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        send_cmd(1'b1, 32'h10, 32'h0000_00A5, 4'hF);
        wait_rsp(cyc);
        check_eq("wr_latency", cyc, 3);
        check_eq("wr_resp", {rsp_timeout, rsp_resp}, 3'b000);
        check_eq("wr_rdata", rsp_rdata, 32'd0);
        check_eq("wr_cmd_ready_in_rsp", cmd_ready, 0);
        check_eq("wr_hs_counts", {8'(aw_hs_cnt - aw0), 8'(w_hs_cnt - w0), 8'(b_hs_cnt - b0)}, 24'h010101);
        check_eq("wr_bus_values", {aw_last, w_last}, {32'h10, 32'hA5});
        check_eq("wr_strb", strb_last, 4'hF);
        check_eq("wr_wlast", wlast_bad, 0);
        take_rsp();

        // W accepted four cycles before AW
        aw_delay = 4;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; awv0 = awv_cycles; wv0 = wv_cycles;
        send_cmd(1'b1, 32'h20, 32'h1234_5678, 4'h3);
        wait_rsp(cyc);
        check_eq("split_latency", cyc, 7);
        check_eq("split_valid_cycles", {8'(awv_cycles - awv0), 8'(wv_cycles - wv0)}, 16'h0501);
        check_eq("split_hs_counts", {8'(aw_hs_cnt - aw0), 8'(w_hs_cnt - w0), 8'(b_hs_cnt - b0)}, 24'h010101);
        check_eq("split_resp", {rsp_timeout, rsp_resp}, 3'b000);
        check_eq("split_bus_values", {aw_last, w_last, 28'd0, strb_last}, {32'h20, 32'h1234_5678, 32'h3});
        check_eq("split_stable", stable_bad, 0);
        take_rsp();
        aw_delay = 0;

        // Read with two slave wait cycles
        r_delay = 2; sl_rdata = 32'hDEAD_BEEF; sl_rresp = 2'b00;
        send_cmd(1'b0, 32'h14, 32'd0, 4'd0);
        wait_rsp(cyc);
        check_eq("rd_latency", cyc, 5);
        check_eq("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("rd_resp", {rsp_timeout, rsp_resp}, 3'b000);
        check_eq("rd_addr", ar_last, 32'h14);
        take_rsp();

        // Zero-wait read with an error response passed straight through
        r_delay = 0; sl_rdata = 32'h0BAD_F00D; sl_rresp = 2'b11;
        send_cmd(1'b0, 32'h18, 32'd0, 4'd0);
        wait_rsp(cyc);
        check_eq("rd0_latency", cyc, 3);
        check_eq("rd0_rdata", rsp_rdata, 32'h0BAD_F00D);
        check_eq("rd0_resp", {rsp_timeout, rsp_resp}, 3'b011);
        take_rsp();
        sl_rresp = 2'b00;

        // Slave never accepts the write: abort after 8 stalled cycles
        hang_wr = 1'b1;
        b0 = b_hs_cnt; awv0 = awv_cycles; wv0 = wv_cycles;
        send_cmd(1'b1, 32'h30, 32'h7777_0000, 4'hF);
        wait_rsp(cyc);
        check_eq("to_latency", cyc, 9);
        check_eq("to_valid_cycles", {8'(awv_cycles - awv0), 8'(wv_cycles - wv0)}, 16'h0808);
        check_eq("to_valids_low", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 3'b000);
        check_eq("to_resp", {rsp_timeout, rsp_resp}, 3'b110);
        check_eq("to_rdata", rsp_rdata, 32'd0);
        check_eq("to_no_b", b_hs_cnt - b0, 0);
        take_rsp();
        hang_wr = 1'b0;

        // Response back-pressure while a new command is already waiting
        send_cmd(1'b1, 32'h40, 32'h5555_AAAA, 4'hC);
        wait_rsp(cyc);
        check_eq("bp_latency", cyc, 3);
        ar0 = ar_hs_cnt;
        sl_rdata = 32'h1111_2222;
        cmd_write = 1'b0; cmd_addr = 32'h44; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_eq("bp_rsp_valid", rsp_valid, 1);
            check_eq("bp_cmd_ready", cmd_ready, 0);
            check_eq("bp_rsp_stable", {rsp_timeout, rsp_resp, rsp_rdata}, 35'd0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check_eq("bp_after_hs", {rsp_valid, cmd_ready}, 2'b01);
        check_eq("bp_no_early_ar", ar_hs_cnt - ar0, 0);
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
        wait_rsp(cyc);
        check_eq("bp_rd_latency", cyc, 3);
        check_eq("bp_rd_rdata", rsp_rdata, 32'h1111_2222);
        check_eq("bp_rd_addr", ar_last, 32'h44);
        take_rsp();

        // Reset while waiting for B abandons the write
        hold_b = 1'b1;
        b0 = b_hs_cnt;
        send_cmd(1'b1, 32'h50, 32'h0F0F_0F0F, 4'h5);
        @(negedge aclk);
        @(negedge aclk);
        check_eq("mid_bready", axi_bus.bready, 1);
        areset = 1'b1;
        @(negedge aclk);
        check_eq("mid_rst_ctrl", {cmd_ready, rsp_valid, axi_bus.awvalid, axi_bus.wvalid,
                                  axi_bus.bready, axi_bus.arvalid, axi_bus.rready, axi_bus.wlast}, 8'd0);
        check_eq("mid_rst_bus", {axi_bus.awaddr, axi_bus.araddr}, 64'd0);
        check_eq("mid_rst_wdata", {axi_bus.wstrb, axi_bus.wdata}, 36'd0);
        check_eq("mid_rst_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, 35'd0);
        areset = 1'b0; hold_b = 1'b0;
        #1;
        check_eq("mid_rst_cmd_ready", cmd_ready, 1);
        repeat (4) @(negedge aclk);
        check_eq("mid_rst_no_rsp", {rsp_valid, 8'(b_hs_cnt - b0)}, 9'd0);
        send_cmd(1'b1, 32'h60, 32'h0000_CAFE, 4'hF);
        wait_rsp(cyc);
        check_eq("post_rst_latency", cyc, 3);
        check_eq("post_rst_resp", {rsp_timeout, rsp_resp, rsp_rdata}, 35'd0);
        check_eq("post_rst_bus", {aw_last, w_last}, {32'h60, 32'h0000_CAFE});
        take_rsp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
